// File: rtl/down_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : down_timer_ctrl
// Purpose  : Prescaled, loadable down-count timer controller. Divides clk by
//            PRESCALE to form count ticks and counts a loaded value down to 0.
//            It reports busy and the live count, and pulses tick and done for
//            one cycle each.
// Options  : AUTO_RELOAD_EN - when defined, terminal count reloads from
//            load_val and keeps running instead of stopping in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module down_timer_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    // Prescaler is at least one bit wide so PRESCALE=1 still elaborates.
    localparam int               PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] prescaler;

    // Control FSM: start/pause/resume, prescaled decrement and terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            prescaler <= '0;
            busy      <= 1'b0;
            tick      <= 1'b0;
            done      <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // stop is ignored here; start always wins from rest.
                    if (start) begin
                        prescaler <= '0;
                        if (load_val == '0) begin
                            count <= '0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            count <= load_val;
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        // Pause holds count and prescaler exactly where they are.
                        state <= ST_PAUSE;
                    end else if (prescaler != PRE_LAST) begin
                        prescaler <= prescaler + PRE_ONE;
                    end else begin
                        prescaler <= '0;
                        tick      <= 1'b1;
                        // count is never 0 in RUN, but treat 0 as terminal so
                        // the counter can never wrap below zero.
                        if (count <= COUNT_ONE) begin
                            done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (load_val != '0) begin
                                count <= load_val;
                            end else begin
                                count <= '0;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end
`else
                            count <= '0;
                            busy  <= 1'b0;
                            state <= ST_DONE;
`endif
                        end else begin
                            count <= count - COUNT_ONE;
                        end
                    end
                end

                ST_PAUSE: begin
                    // Resume without reload; start+stop together keeps us paused.
                    if (start && !stop) begin
                        state <= ST_RUN;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
